// File: rtl/taylor_pkg.sv
// taylor_pkg: shared constants and types for the Taylor-evaluator job scheduler.
//   W         : angle/result width, Q(W-10).10 fixed point
//   FXP_SHIFT : number of fractional bits in the fixed-point format
//   TIMEOUT   : maximum cycles spent waiting on the evaluator for one job
//   sched_state_e : scheduler FSM state encoding (also visible on dbg_state)
package taylor_pkg;

  localparam int W         = 24;
  localparam int FXP_SHIFT = 10;
  localparam int TIMEOUT   = 16;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_LOW  = 3'd2,
    S_WAIT_HIGH = 3'd3,
    S_RELEASE   = 3'd4,
    S_RECOVER   = 3'd5
  } sched_state_e;

endpackage

// File: rtl/taylor_rr_arb.sv
// taylor_rr_arb: two-requester round-robin arbiter.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   req[1:0]     : request from requester 1 / requester 0
//   advance      : a grant is being taken this cycle; move the pointer
//   grant[1:0]   : one-hot grant (all zero when nothing is requested)
// The pointer names the requester that wins a tie. It is 0 after reset and,
// whenever a grant is taken, moves to the requester that was not granted.
module taylor_rr_arb (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);
  import taylor_pkg::*;

  logic ptr;

  // A lone request always wins; the pointer only breaks ties.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

  // After granting requester 0 the pointer goes to 1, and vice versa.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (advance && (grant != 2'b00)) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/taylor_sched.sv
// taylor_sched: arbitrates jobs from two requesters onto one Taylor evaluator
// (instantiated beside this block) and returns tagged results.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   req0/req1, angle0/1   : job requests (held until acked), angles stable while req high
//   ack0/ack1             : one-cycle pulse when that requester's job is captured
//   res_valid/id/data/err : one-cycle result strobe, owner, result (0 on error), timeout flag
//   core_start/angle      : evaluator start pulse and operand
//   core_ready/result     : evaluator ready flag and result
//   core_reset            : evaluator reset (held during reset and for 2 cycles on timeout)
//   timeout_err           : sticky timeout indication, cleared only by reset
//   dbg_state             : current FSM state (sched_state_e encoding)
//
// Handshakes: a requester raises reqN and keeps it (and angleN) steady until it
// sees ackN for one cycle; the job is owned by the scheduler from then on. The
// evaluator is started by a one-cycle core_start; its result is valid when
// core_ready rises after having been seen low, and a second core_start pulse
// returns it to idle. res_valid is a one-cycle strobe with no back-pressure.
module taylor_sched #(
  parameter int W       = taylor_pkg::W,
  parameter int TIMEOUT = taylor_pkg::TIMEOUT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] angle0,
  input  logic [W-1:0] angle1,
  output logic         ack0,
  output logic         ack1,
  output logic         res_valid,
  output logic         res_id,
  output logic [W-1:0] res_data,
  output logic         res_err,
  output logic         core_start,
  output logic [W-1:0] core_angle,
  input  logic         core_ready,
  input  logic [W-1:0] core_result,
  output logic         core_reset,
  output logic         timeout_err,
  output logic [2:0]   dbg_state
);
  import taylor_pkg::*;

  localparam int             WCW        = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(TIMEOUT);

  sched_state_e   state;
  sched_state_e   state_next;
  logic [1:0]     grant;
  logic           grant_fire;
  logic           capture;
  logic           enter_recover;
  logic [W-1:0]   angle_q;
  logic [W-1:0]   result_q;
  logic           owner_q;
  logic           rec_first;
  logic [WCW-1:0] wait_cnt;
  logic [WCW-1:0] wait_cnt_inc;
  logic           wait_expired;

  taylor_rr_arb u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     ({req1, req0}),
    .advance (grant_fire),
    .grant   (grant)
  );

  // Saturating wait counter; the value after this cycle decides the timeout,
  // so exactly TIMEOUT cycles are spent in WAIT_LOW/WAIT_HIGH before RECOVER.
  always_comb begin
    wait_cnt_inc = wait_cnt;
    if (wait_cnt != WAIT_LIMIT) begin
      wait_cnt_inc = wait_cnt + WCW'(1);
    end
  end

  assign wait_expired = (wait_cnt_inc == WAIT_LIMIT);

  always_comb begin
    state_next    = state;
    grant_fire    = 1'b0;
    capture       = 1'b0;
    enter_recover = 1'b0;
    case (state)
      S_IDLE: begin
        if (req0 || req1) begin
          grant_fire = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_next = S_WAIT_LOW;
      end
      // A ready still high here belongs to the previous job; wait for it to drop.
      S_WAIT_LOW: begin
        if (!core_ready) begin
          state_next = S_WAIT_HIGH;
        end else if (wait_expired) begin
          state_next    = S_RECOVER;
          enter_recover = 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        if (core_ready) begin
          capture    = 1'b1;
          state_next = S_RELEASE;
        end else if (wait_expired) begin
          state_next    = S_RECOVER;
          enter_recover = 1'b1;
        end
      end
      S_RELEASE: begin
        state_next = S_IDLE;
      end
      // rec_first marks the first of the two core_reset cycles.
      S_RECOVER: begin
        if (!rec_first) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      res_valid   <= 1'b0;
      res_id      <= 1'b0;
      res_data    <= '0;
      res_err     <= 1'b0;
      timeout_err <= 1'b0;
      angle_q     <= '0;
      result_q    <= '0;
      owner_q     <= 1'b0;
      rec_first   <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      state     <= state_next;
      ack0      <= grant_fire & grant[0];
      ack1      <= grant_fire & grant[1];
      res_valid <= 1'b0;
      rec_first <= enter_recover;

      if (grant_fire) begin
        angle_q <= grant[1] ? angle1 : angle0;
        owner_q <= grant[1];
      end

      if (state == S_ISSUE) begin
        wait_cnt <= '0;
      end else if ((state == S_WAIT_LOW) || (state == S_WAIT_HIGH)) begin
        wait_cnt <= wait_cnt_inc;
      end

      if (capture) begin
        result_q <= core_result;
      end

      // Result strobe lands in the cycle after RELEASE (the next IDLE), so it
      // can never coincide with an ack, which also needs a full IDLE cycle.
      if (state == S_RELEASE) begin
        res_valid <= 1'b1;
        res_id    <= owner_q;
        res_data  <= result_q;
        res_err   <= 1'b0;
      end else if (enter_recover) begin
        res_valid   <= 1'b1;
        res_id      <= owner_q;
        res_data    <= '0;
        res_err     <= 1'b1;
        timeout_err <= 1'b1;
      end
    end
  end

  // Gated by reset so the evaluator sees no start while reset is asserted.
  assign core_start = !reset && ((state == S_ISSUE) || (state == S_RELEASE));
  assign core_reset = reset || (state == S_RECOVER);
  assign core_angle = angle_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_taylor_sched.sv
module tb_taylor_sched;

  localparam int W = 24;
  localparam logic [W-1:0] JUNK = 24'hBADBAD;

  logic         clock = 1'b0;
  logic         reset;
  logic         req0, req1;
  logic [W-1:0] angle0, angle1;
  logic         ack0, ack1;
  logic         res_valid, res_id, res_err;
  logic [W-1:0] res_data;
  logic         core_start, core_reset;
  logic [W-1:0] core_angle;
  logic         core_ready;
  logic [W-1:0] core_result;
  logic         timeout_err;
  logic [2:0]   dbg_state;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // core behaviour: 0 compliant, 1 ready stuck at 0, 2 stale ready held after start
  int core_mode = 0;
  int cst = 0;
  int ccnt = 0;
  logic [W-1:0] cang = '0;
  logic core_ready_m = 1'b1;
  logic [W-1:0] core_res_m = '0;

  taylor_sched #(.W(W), .TIMEOUT(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .req0        (req0),
    .req1        (req1),
    .angle0      (angle0),
    .angle1      (angle1),
    .ack0        (ack0),
    .ack1        (ack1),
    .res_valid   (res_valid),
    .res_id      (res_id),
    .res_data    (res_data),
    .res_err     (res_err),
    .core_start  (core_start),
    .core_angle  (core_angle),
    .core_ready  (core_ready),
    .core_result (core_result),
    .core_reset  (core_reset),
    .timeout_err (timeout_err),
    .dbg_state   (dbg_state)
  );

  // clock/reset block
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural evaluator: two-term cosine 1 - x^2/2 in Q.10.
  function automatic logic [W-1:0] cos2(input logic [W-1:0] a);
    int x;
    x = int'(a);
    return W'(1024 - ((x * x) >>> 11));
  endfunction

  always @(posedge clock) begin
    if (core_reset) begin
      cst <= 0;
      ccnt <= 0;
      core_ready_m <= 1'b1;
      core_res_m <= JUNK;
    end else begin
      case (cst)
        0: if (core_start) begin
          cang <= core_angle;
          if (core_mode == 2) begin
            cst <= 3;
            ccnt <= 2;
          end else begin
            cst <= 1;
            ccnt <= 4;
            core_ready_m <= 1'b0;
          end
        end
        3: if (ccnt == 0) begin
          cst <= 1;
          ccnt <= 4;
          core_ready_m <= 1'b0;
        end else begin
          ccnt <= ccnt - 1;
        end
        1: if (ccnt == 0) begin
          cst <= 2;
          core_ready_m <= 1'b1;
          core_res_m <= cos2(cang);
        end else begin
          ccnt <= ccnt - 1;
        end
        2: if (core_start) begin
          cst <= 0;
          core_res_m <= JUNK;
        end
        default: cst <= 0;
      endcase
    end
  end

  assign core_ready  = (core_mode == 1) ? 1'b0 : core_ready_m;
  assign core_result = core_res_m;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_ack(output int who, output int at, output bit ok);
    who = -1;
    at = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (ack0 || ack1) begin
        who = ack1 ? 1 : 0;
        at = cyc;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_res(output int at, output logic id, output logic [W-1:0] data,
                          output logic err, output bit ok, output int ov);
    at = 0;
    id = 1'bx;
    data = 'x;
    err = 1'bx;
    ok = 1'b0;
    ov = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (res_valid && (ack0 || ack1)) ov++;
      if (res_valid) begin
        at = cyc;
        id = res_id;
        data = res_data;
        err = res_err;
        ok = 1'b1;
        break;
      end
    end
  endtask

  // tests
  task automatic test_reset();
    reset = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    angle0 = '0;
    angle1 = '0;
    repeat (2) @(negedge clock);
    n_total++; if (ack0 !== 1'b0 || ack1 !== 1'b0) $display("FAIL reset_ack: got %b%b want 00", ack1, ack0); else n_pass++;
    n_total++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b want 0", res_valid); else n_pass++;
    n_total++; if (res_id !== 1'b0 || res_err !== 1'b0 || res_data !== '0)
      $display("FAIL reset_res_fields: got id=%b err=%b data=%0d want 0/0/0", res_id, res_err, res_data); else n_pass++;
    n_total++; if (core_start !== 1'b0) $display("FAIL reset_core_start: got %b want 0", core_start); else n_pass++;
    n_total++; if (core_angle !== '0) $display("FAIL reset_core_angle: got %0d want 0", core_angle); else n_pass++;
    n_total++; if (core_reset !== 1'b1) $display("FAIL reset_core_reset: got %b want 1", core_reset); else n_pass++;
    n_total++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err: got %b want 0", timeout_err); else n_pass++;
    n_total++; if (dbg_state !== 3'd0) $display("FAIL reset_state: got %0d want 0", dbg_state); else n_pass++;
    reset = 1'b0;
    @(negedge clock);
    n_total++; if (core_reset !== 1'b0) $display("FAIL post_reset_core_reset: got %b want 0", core_reset); else n_pass++;
  endtask

  task automatic test_single();
    int who, t0, t1, tr, ov;
    bit ok;
    logic id, err;
    logic [W-1:0] data;
    core_mode = 0;
    @(negedge clock);
    angle0 = '0;
    req0 = 1'b1;
    wait_ack(who, t0, ok);
    req0 = 1'b0;
    n_total++; if (!ok || who != 0) $display("FAIL single_ack: got ok=%0d who=%0d want ack0", ok, who); else n_pass++;
    n_total++; if (core_start !== 1'b1) $display("FAIL single_issue_start: got %b want 1", core_start); else n_pass++;
    // request from the other side while busy: must wait for the next IDLE
    @(negedge clock);
    req1 = 1'b1;
    angle1 = 24'd256;
    wait_res(tr, id, data, err, ok, ov);
    n_total++; if (!ok || (tr - t0) != 8) $display("FAIL single_latency: got %0d want 8", tr - t0); else n_pass++;
    n_total++; if (id !== 1'b0 || err !== 1'b0) $display("FAIL single_id_err: got id=%b err=%b want 0/0", id, err); else n_pass++;
    n_total++; if (data !== 24'd1024) $display("FAIL single_data: got %0d want 1024", data); else n_pass++;
    n_total++; if (ov != 0) $display("FAIL single_overlap: got %0d want 0", ov); else n_pass++;
    wait_ack(who, t1, ok);
    req1 = 1'b0;
    n_total++; if (!ok || who != 1 || (t1 - t0) != 9)
      $display("FAIL late_req_ack: got who=%0d at +%0d want ack1 at +9", who, t1 - t0); else n_pass++;
    wait_res(tr, id, data, err, ok, ov);
    n_total++; if (!ok || id !== 1'b1 || data !== 24'd992)
      $display("FAIL late_req_result: got id=%b data=%0d want 1/992", id, data); else n_pass++;
  endtask

  task automatic test_fairness();
    int exp_who[3] = '{0, 1, 0};
    int who, t, tr, ov;
    bit ok;
    logic id, err;
    logic [W-1:0] data;
    logic [W-1:0] exp_angle, exp_data;
    do_reset();
    core_mode = 0;
    angle0 = 24'd512;
    angle1 = 24'd256;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int j = 0; j < 3; j++) begin
      exp_angle = (exp_who[j] == 1) ? 24'd256 : 24'd512;
      exp_data = (exp_who[j] == 1) ? 24'd992 : 24'd896;
      wait_ack(who, t, ok);
      if (j == 2) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      n_total++; if (!ok || who != exp_who[j]) $display("FAIL rr_grant_%0d: got %0d want %0d", j, who, exp_who[j]); else n_pass++;
      n_total++; if (core_angle !== exp_angle) $display("FAIL rr_angle_%0d: got %0d want %0d", j, core_angle, exp_angle); else n_pass++;
      wait_res(tr, id, data, err, ok, ov);
      n_total++; if (!ok || id !== exp_who[j][0] || data !== exp_data || err !== 1'b0)
        $display("FAIL rr_result_%0d: got id=%b data=%0d err=%b want %0d/%0d/0", j, id, data, err, exp_who[j], exp_data); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int who, t0, n_ack, n_res, ov, bad_data, extra;
    int ack_at[3];
    bit ok;
    do_reset();
    core_mode = 0;
    angle0 = 24'd1024;
    req0 = 1'b1;
    wait_ack(who, t0, ok);
    n_ack = 1;
    ack_at[0] = t0;
    n_res = 0;
    ov = 0;
    bad_data = 0;
    extra = 0;
    for (int i = 0; i < 26; i++) begin
      @(negedge clock);
      if (res_valid && (ack0 || ack1)) ov++;
      if (res_valid) begin
        n_res++;
        if (res_data !== 24'd512 || res_id !== 1'b0) bad_data++;
      end
      if (ack0 || ack1) begin
        if (n_ack < 3 && ack0) begin
          ack_at[n_ack] = cyc;
          n_ack++;
          if (n_ack == 3) req0 = 1'b0;
        end else begin
          extra++;
        end
      end
    end
    n_total++; if (!ok || n_ack != 3) $display("FAIL b2b_ack_count: got %0d want 3", n_ack); else n_pass++;
    n_total++; if (n_ack == 3 && (ack_at[1] - t0 != 9 || ack_at[2] - t0 != 18))
      $display("FAIL b2b_ack_spacing: got +%0d,+%0d want +9,+18", ack_at[1] - t0, ack_at[2] - t0); else n_pass++;
    n_total++; if (ov != 0) $display("FAIL b2b_overlap: got %0d want 0", ov); else n_pass++;
    n_total++; if (n_res != 3 || bad_data != 0) $display("FAIL b2b_results: got %0d results, %0d bad, want 3/0", n_res, bad_data); else n_pass++;
    n_total++; if (extra != 0) $display("FAIL b2b_extra_ack: got %0d want 0", extra); else n_pass++;
  endtask

  task automatic test_timeout();
    int who, t0, rec_at, res_at, cr_cnt, tr, ov;
    bit ok;
    logic te_before, r_id, r_err, id, err;
    logic [W-1:0] r_data, data;
    do_reset();
    core_mode = 1;
    angle1 = 24'd100;
    req1 = 1'b1;
    wait_ack(who, t0, ok);
    req1 = 1'b0;
    n_total++; if (!ok || who != 1) $display("FAIL to_ack: got who=%0d want 1", who); else n_pass++;
    rec_at = -1;
    res_at = -1;
    cr_cnt = 0;
    te_before = 1'bx;
    r_id = 1'bx;
    r_err = 1'bx;
    r_data = 'x;
    for (int i = 0; i < 24; i++) begin
      @(negedge clock);
      if (cyc == t0 + 16) te_before = timeout_err;
      if (dbg_state == 3'd5 && rec_at < 0) rec_at = cyc;
      if (core_reset) cr_cnt++;
      if (res_valid && res_at < 0) begin
        res_at = cyc;
        r_id = res_id;
        r_err = res_err;
        r_data = res_data;
      end
    end
    n_total++; if (te_before !== 1'b0) $display("FAIL to_flag_before: got %b want 0", te_before); else n_pass++;
    n_total++; if (rec_at - t0 != 17) $display("FAIL to_recover_at: got +%0d want +17", rec_at - t0); else n_pass++;
    n_total++; if (res_at - t0 != 17) $display("FAIL to_res_at: got +%0d want +17", res_at - t0); else n_pass++;
    n_total++; if (r_err !== 1'b1 || r_data !== '0 || r_id !== 1'b1)
      $display("FAIL to_res_fields: got err=%b data=%0d id=%b want 1/0/1", r_err, r_data, r_id); else n_pass++;
    n_total++; if (cr_cnt != 2) $display("FAIL to_core_reset_len: got %0d want 2", cr_cnt); else n_pass++;
    n_total++; if (timeout_err !== 1'b1) $display("FAIL to_flag_set: got %b want 1", timeout_err); else n_pass++;
    n_total++; if (dbg_state !== 3'd0) $display("FAIL to_back_idle: got %0d want 0", dbg_state); else n_pass++;
    // a good job afterwards must not clear the sticky flag
    core_mode = 0;
    angle0 = '0;
    req0 = 1'b1;
    wait_ack(who, t0, ok);
    req0 = 1'b0;
    wait_res(tr, id, data, err, ok, ov);
    n_total++; if (!ok || err !== 1'b0 || data !== 24'd1024)
      $display("FAIL to_recovered_job: got err=%b data=%0d want 0/1024", err, data); else n_pass++;
    n_total++; if (timeout_err !== 1'b1) $display("FAIL to_flag_sticky: got %b want 1", timeout_err); else n_pass++;
    do_reset();
    @(negedge clock);
    n_total++; if (timeout_err !== 1'b0) $display("FAIL to_flag_cleared: got %b want 0", timeout_err); else n_pass++;
  endtask

  task automatic test_reset_mid_job();
    int who, t0, t1, nres, bad_ack, tr, ov;
    bit ok;
    logic id, err;
    logic [W-1:0] data;
    do_reset();
    core_mode = 0;
    angle0 = '0;
    req0 = 1'b1;
    wait_ack(who, t0, ok);
    req0 = 1'b0;
    nres = 0;
    bad_ack = 0;
    repeat (4) begin
      @(negedge clock);
      if (res_valid) nres++;
    end
    reset = 1'b1;
    angle1 = 24'd256;
    req1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      if (res_valid) nres++;
      if (ack0 || ack1) bad_ack++;
      n_total++; if (core_reset !== 1'b1) $display("FAIL mid_core_reset_%0d: got %b want 1", i, core_reset); else n_pass++;
    end
    n_total++; if (dbg_state !== 3'd0) $display("FAIL mid_state_idle: got %0d want 0", dbg_state); else n_pass++;
    reset = 1'b0;
    @(negedge clock);
    t1 = cyc;
    if (res_valid) nres++;
    n_total++; if (ack1 !== 1'b1 || ack0 !== 1'b0) $display("FAIL mid_first_ack: got %b%b want 10", ack1, ack0); else n_pass++;
    req1 = 1'b0;
    n_total++; if (nres != 0 || bad_ack != 0) $display("FAIL mid_abandon: got %0d results %0d acks want 0/0", nres, bad_ack); else n_pass++;
    wait_res(tr, id, data, err, ok, ov);
    n_total++; if (!ok || (tr - t1) != 8 || id !== 1'b1 || data !== 24'd992)
      $display("FAIL mid_next_job: got +%0d id=%b data=%0d want +8/1/992", tr - t1, id, data); else n_pass++;
  endtask

  task automatic test_stale_ready();
    int who, t0, res_at;
    bit ok;
    logic [2:0] st3;
    logic r_err;
    logic [W-1:0] r_data;
    do_reset();
    core_mode = 2;
    angle0 = 24'd256;
    req0 = 1'b1;
    wait_ack(who, t0, ok);
    req0 = 1'b0;
    res_at = -1;
    st3 = 'x;
    r_err = 1'bx;
    r_data = 'x;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (cyc == t0 + 3) st3 = dbg_state;
      if (res_valid && res_at < 0) begin
        res_at = cyc;
        r_data = res_data;
        r_err = res_err;
      end
    end
    n_total++; if (!ok || who != 0) $display("FAIL stale_ack: got who=%0d want 0", who); else n_pass++;
    n_total++; if (st3 !== 3'd2) $display("FAIL stale_wait_low: got %0d want 2", st3); else n_pass++;
    n_total++; if (res_at - t0 != 11) $display("FAIL stale_res_at: got +%0d want +11", res_at - t0); else n_pass++;
    n_total++; if (r_data !== 24'd992 || r_err !== 1'b0) $display("FAIL stale_data: got %0d err=%b want 992/0", r_data, r_err); else n_pass++;
    core_mode = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_back_to_back();
    test_timeout();
    test_reset_mid_job();
    test_stale_ready();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/taylor_sched.md
TAYLOR_SCHED -- requirements
Module: taylor_sched

Interface
REQ-001 Parameter W, default 24, SHALL set the angle/result width in Q(W-10).10 fixed point.
REQ-002 Parameter TIMEOUT, default 16, SHALL set the maximum cycles spent waiting on the core per job.
REQ-003 clock  in  1  SHALL be the single clock; all logic on its rising edge.
REQ-004 reset  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 req0, req1  in  1 each  SHALL be the requester job requests; held high until acked.
REQ-006 angle0, angle1  in  W each  SHALL be the requester angles; stable while the matching req is high.
REQ-007 ack0, ack1  out  1 each  SHALL be one-cycle pulses marking job capture.
REQ-008 res_valid  out  1  SHALL be a one-cycle result strobe.
REQ-009 res_id  out  1  SHALL name the requester owning the result.
REQ-010 res_data  out  W  SHALL carry the result; 0 when res_err=1.
REQ-011 res_err  out  1  SHALL flag that the result was aborted by timeout.
REQ-012 core_start  out  1  SHALL drive the evaluator's start input.
REQ-013 core_angle  out  W  SHALL drive the evaluator's angle input.
REQ-014 core_ready  in  1  SHALL be the evaluator's ready output.
REQ-015 core_result  in  W  SHALL be the evaluator's result output.
REQ-016 core_reset  out  1  SHALL drive the evaluator's reset input.
REQ-017 timeout_err  out  1  SHALL be a sticky timeout flag, cleared only by reset.

Function
REQ-018 States SHALL be IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, RELEASE, RECOVER.
REQ-019 IDLE: with any req high, grant one requester, pulse its ack, latch its angle and id, go to ISSUE; otherwise stay in IDLE.
REQ-020 Arbitration SHALL be round-robin: one pointer, 0 after reset; with both requests high the pointer side wins; after any grant the pointer moves to the other requester.
REQ-021 A single request SHALL be granted regardless of pointer.
REQ-022 A req arriving outside IDLE SHALL receive no ack until the next IDLE.
REQ-023 core_angle SHALL hold the latched angle from ISSUE through RELEASE.
REQ-024 ISSUE: core_start=1 for exactly one cycle, then go to WAIT_LOW.
REQ-025 WAIT_LOW: wait for core_ready==0, which discards a stale ready from the previous job, then go to WAIT_HIGH.
REQ-026 WAIT_HIGH: on core_ready==1, capture core_result and go to RELEASE.
REQ-027 RELEASE: core_start=1 for one cycle to return the core to idle, register res_valid=1, res_id, res_data=captured result and res_err=0, then go to IDLE with core_start=0.
REQ-028 core_start SHALL be 0 in all states except ISSUE and RELEASE.
REQ-029 A wait counter SHALL clear on entering WAIT_LOW and count cycles across WAIT_LOW and WAIT_HIGH.
REQ-030 When the wait counter reaches TIMEOUT the block SHALL go to RECOVER.
REQ-031 RECOVER: core_reset=1 for 2 cycles; res_valid=1, res_err=1, res_data=0, res_id=owner in the first cycle; set timeout_err; then go to IDLE.
REQ-032 With a compliant core, res_valid SHALL appear exactly 8 cycles after the ack cycle, and the next ack SHALL come no earlier than 9 cycles after it.
REQ-033 res_valid and ack SHALL never be high in the same cycle.
REQ-034 Arithmetic: the block SHALL perform no arithmetic on angles or results; the wait counter SHALL be sized as $clog2(TIMEOUT+1) bits and SHALL saturate.

Reset
REQ-035 While reset is high: state=IDLE, pointer=0, ack0=ack1=0, res_valid=0, res_id=0, res_data=0, res_err=0, core_start=0, core_angle=0, timeout_err=0, core_reset=1.
REQ-036 Reset mid-job SHALL abandon the job, issue no res_valid and leave no pending ack.

Structure
REQ-037 Package taylor_pkg SHALL hold W, FXP_SHIFT=10, TIMEOUT and the state enum typedef.
REQ-038 The round-robin grant SHALL be one sub-module, taylor_rr_arb, with two requests, grant one-hot and a pointer update.
REQ-039 The evaluator SHALL be instantiated beside taylor_sched, not inside it.

Verification
REQ-040 Check: req0=1, angle0=0 with the real core -> ack0 at cycle 0; res_valid at cycle 8 with res_id=0, res_data=1024, res_err=0.
REQ-041 Check: req0 and req1 high together for three jobs after reset -> grant order 0, 1, 0, each result tagged with the correct res_id.
REQ-042 Check: req0 held high continuously -> acks at cycles 0, 9, 18; no overlap of res_valid and ack.
REQ-043 Check: stub core with core_ready stuck at 0 -> RECOVER after 16 wait cycles; res_valid=1, res_err=1, res_data=0; core_reset high 2 cycles; timeout_err stays 1 until reset.
REQ-044 Check: reset pulsed 4 cycles after ack0 -> no res_valid, core_reset high during reset, a following req1 is acked in the first IDLE cycle.
REQ-045 Check: stub core holding stale core_ready=1 at job start -> no capture until ready falls then rises again.
